debug_probe_ctrl: RTL

Host-side initiator for the core's debug port. It drives `debug_en`, `debug_step` and `debug_addr`, and reads back `debug_data`. It accepts halt, run, single-step and dump commands over a valid/ready command port. A dump sweeps the debug address space (register file and test signals) and emits each word on a valid/ready output stream. It sits between a host link (UART/JTAG bridge) and the RV32 pipeline's debug inputs.

---
 rtl/debug_probe_pkg.sv | 22 ++
 rtl/debug_step_gen.sv | 56 +++++
 rtl/debug_probe_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/debug_probe_pkg.sv
// Shared types and widths for the debug probe controller and its step generator.
package debug_probe_pkg;

   localparam int DBG_ADDR_W = 7;
   localparam int DBG_DATA_W = 32;

   typedef enum logic [1:0] {
      OP_RUN  = 2'd0,
      OP_HALT = 2'd1,
      OP_STEP = 2'd2,
      OP_DUMP = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_HI   = 3'd1,
      S_LO   = 3'd2,
      D_ADDR = 3'd3,
      D_OUT  = 3'd4
   } state_e;

endpackage

// File: rtl/debug_step_gen.sv
// Generates count step pulses (STEP_HI cycles high, STEP_LO cycles low) on the core's step clock.
module debug_step_gen
   import debug_probe_pkg::*;
#(
   parameter int STEP_HI = 4,
   parameter int STEP_LO = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] count,
   output logic        debug_step,
   output logic        phase_end,
   output logic        done
);

   localparam int PH_MAX = (STEP_HI > STEP_LO) ? STEP_HI : STEP_LO;
   localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [PW-1:0] HI_END = PW'(STEP_HI - 1);
   localparam logic [PW-1:0] LO_END = PW'(STEP_LO - 1);

   logic          step_r;
   logic [PW-1:0] phase_cnt_r;
   logic [15:0]   steps_r;

   // phase_end marks the final cycle of the current high or low phase; done is the final low phase
   assign phase_end  = (steps_r != 16'd0) && (step_r ? (phase_cnt_r == HI_END) : (phase_cnt_r == LO_END));
   assign done       = phase_end && !step_r && (steps_r == 16'd1);
   assign debug_step = step_r;

   // Phase counter and remaining-steps counter
   always_ff @(posedge clk) begin
      if (rst) begin
         step_r      <= 1'b0;
         phase_cnt_r <= '0;
         steps_r     <= 16'd0;
      end else if (start) begin
         step_r      <= (count != 16'd0);
         phase_cnt_r <= '0;
         steps_r     <= count;
      end else if (phase_end) begin
         phase_cnt_r <= '0;
         if (step_r) begin
            step_r <= 1'b0;
         end else begin
            steps_r <= steps_r - 16'd1;
            step_r  <= (steps_r != 16'd1);
         end
      end else if (steps_r != 16'd0) begin
         phase_cnt_r <= phase_cnt_r + PW'(1);
      end else begin
         phase_cnt_r <= phase_cnt_r;
      end
   end

endmodule

// File: rtl/debug_probe_ctrl.sv
// Host-side debug port initiator: run/halt/step control of the core and a full debug-space dump stream.
module debug_probe_ctrl
   import debug_probe_pkg::*;
#(
   parameter int STEP_HI       = 4,
   parameter int STEP_LO       = 4,
   parameter int SETTLE        = 2,
   parameter int DUMP_WORDS    = 64,
   parameter int HALT_ON_RESET = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_count,
   output logic        debug_en,
   output logic        debug_step,
   output logic [6:0]  debug_addr,
   input  logic [31:0] debug_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [6:0]  out_addr,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        busy
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0]         SETTLE_END = SW'(SETTLE - 1);
   localparam logic [DBG_ADDR_W-1:0] LAST_ADDR  = DBG_ADDR_W'(DUMP_WORDS - 1);

   state_e                  state_r, state_s;
   logic                    debug_en_r, debug_en_s;
   logic [DBG_ADDR_W-1:0]   debug_addr_r, debug_addr_s;
   logic                    out_valid_r, out_valid_s;
   logic [DBG_ADDR_W-1:0]   out_addr_r, out_addr_s;
   logic [DBG_DATA_W-1:0]   out_data_r, out_data_s;
   logic                    out_last_r, out_last_s;
   logic [SW-1:0]           settle_r, settle_s;
   logic                    busy_r;
   logic                    accept_s;
   logic                    step_start_s;
   logic                    step_phase_end_s;
   logic                    step_done_s;

   assign cmd_ready = (state_r == IDLE) && !rst;
   assign accept_s  = cmd_valid && cmd_ready;

   debug_step_gen #(
      .STEP_HI (STEP_HI),
      .STEP_LO (STEP_LO)
   ) u_step_gen (
      .clk        (clk),
      .rst        (rst),
      .start      (step_start_s),
      .count      (cmd_count),
      .debug_step (debug_step),
      .phase_end  (step_phase_end_s),
      .done       (step_done_s)
   );

   // Command decode, step phase tracking and dump sweep
   always_comb begin
      state_s      = state_r;
      debug_en_s   = debug_en_r;
      debug_addr_s = debug_addr_r;
      out_valid_s  = out_valid_r;
      out_addr_s   = out_addr_r;
      out_data_s   = out_data_r;
      out_last_s   = out_last_r;
      settle_s     = settle_r;
      step_start_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               case (op_e'(cmd_op))
                  OP_RUN:  debug_en_s = 1'b0;
                  OP_HALT: debug_en_s = 1'b1;
                  OP_STEP: begin
                     debug_en_s = 1'b1;
                     if (cmd_count != 16'd0) begin
                        step_start_s = 1'b1;
                        state_s      = S_HI;
                     end else begin
                        state_s = IDLE;
                     end
                  end
                  OP_DUMP: begin
                     debug_addr_s = 7'd0;
                     settle_s     = '0;
                     state_s      = D_ADDR;
                  end
                  default: state_s = IDLE;
               endcase
            end else begin
               state_s = IDLE;
            end
         end
         S_HI: begin
            if (step_phase_end_s) begin
               state_s = S_LO;
            end else begin
               state_s = S_HI;
            end
         end
         S_LO: begin
            if (step_done_s) begin
               state_s = IDLE;
            end else if (step_phase_end_s) begin
               state_s = S_HI;
            end else begin
               state_s = S_LO;
            end
         end
         // Capture once debug_data has had SETTLE cycles to follow debug_addr
         D_ADDR: begin
            if (settle_r == SETTLE_END) begin
               out_data_s  = debug_data;
               out_addr_s  = debug_addr_r;
               out_last_s  = (debug_addr_r == LAST_ADDR);
               out_valid_s = 1'b1;
               state_s     = D_OUT;
            end else begin
               settle_s = settle_r + SW'(1);
            end
         end
         D_OUT: begin
            if (out_ready) begin
               out_valid_s = 1'b0;
               if (out_last_r) begin
                  state_s = IDLE;
               end else begin
                  debug_addr_s = debug_addr_r + 7'd1;
                  settle_s     = '0;
                  state_s      = D_ADDR;
               end
            end else begin
               state_s = D_OUT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State and output registers; reset aborts any operation in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         debug_en_r   <= (HALT_ON_RESET != 0);
         debug_addr_r <= 7'd0;
         out_valid_r  <= 1'b0;
         out_addr_r   <= 7'd0;
         out_data_r   <= 32'd0;
         out_last_r   <= 1'b0;
         settle_r     <= '0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         debug_en_r   <= debug_en_s;
         debug_addr_r <= debug_addr_s;
         out_valid_r  <= out_valid_s;
         out_addr_r   <= out_addr_s;
         out_data_r   <= out_data_s;
         out_last_r   <= out_last_s;
         settle_r     <= settle_s;
         busy_r       <= (state_s != IDLE);
      end
   end

   assign debug_en   = debug_en_r;
   assign debug_addr = debug_addr_r;
   assign out_valid  = out_valid_r;
   assign out_addr   = out_addr_r;
   assign out_data   = out_data_r;
   assign out_last   = out_last_r;
   assign busy       = busy_r;

endmodule
